// File: rtl/render_queue.sv
// render_queue
//   Avalon-MM slave that assembles 48-bit sprite draw instructions from three
//   16-bit writes and queues them for vga_display. The consumer reads the head
//   entry combinationally on render_queue_dout and removes it with
//   render_queue_pop_front. An empty queue presents the render sentinel
//   (magic 8'hFF) so the display stage idles.
//
// Ports
//   clk50                  system clock, rising edge
//   reset                  asynchronous, active-high reset
//   chipselect/write/read  Avalon slave strobes (write/read act only with chipselect)
//   address[2:0]           register select
//   writedata[15:0]        write data
//   readdata[15:0]         registered read data, latency 1, holds between reads
//   render_queue_dout      head instruction {magic, x, y, flags} or sentinel
//   render_queue_pop_front consumer pop request (ignored when empty)
//
// Register map
//   W0 stage[47:32]   W1 stage[31:16]   W2 push {stage[47:16], writedata}
//   W4 clear overflow (other write addresses ignored)
//   R0/R1 stage halves   R3 status {full, empty, overflow, 0.., count}
//   (other read addresses return 0)
//
// CNT_W must be <= 13 so count fits below the three status flag bits.

module render_queue #(
   parameter int DEPTH = 25,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic        clk50,
   input  logic        reset,
   input  logic        chipselect,
   input  logic        write,
   input  logic        read,
   input  logic [2:0]  address,
   input  logic [15:0] writedata,
   output logic [15:0] readdata,
   output logic [47:0] render_queue_dout,
   input  logic        render_queue_pop_front
);

   localparam int          PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [47:0] SENTINEL = 48'hFF00_0000_0000;

   typedef struct packed {
      logic [7:0]  magic;
      logic [15:0] x;
      logic [15:0] y;
      logic [7:0]  flags;
   } instr_t;

   instr_t             mem [DEPTH];
   logic [PTR_W-1:0]   rd_ptr;
   logic [PTR_W-1:0]   wr_ptr;
   logic [CNT_W-1:0]   count;
   logic [31:0]        stage;       // instruction bits [47:16]
   logic               overflow;

   logic               wr_en;
   logic               rd_en;
   logic               push_req;
   logic               push_ok;
   logic               push_rej;
   logic               pop;
   logic               ovf_clr;
   logic               full;
   logic               empty;
   logic [15:0]        status;
   logic [15:0]        rd_mux;
   instr_t             push_instr;

   // Pointers wrap explicitly since DEPTH need not be a power of two.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign wr_en    = chipselect & write;
   assign rd_en    = chipselect & read;
   assign full     = (count == CNT_W'(DEPTH));
   assign empty    = (count == '0);
   assign pop      = render_queue_pop_front & ~empty;
   assign push_req = wr_en & (address == 3'd2);
   // A pop in the same cycle frees a slot, so a push at full still lands.
   assign push_ok  = push_req & (~full | pop);
   assign push_rej = push_req & ~push_ok;
   assign ovf_clr  = wr_en & (address == 3'd4);

   // The push uses the stage value from before this edge; no stage write can
   // coincide with it because they share the address bus.
   assign push_instr = instr_t'({stage, writedata});

   assign render_queue_dout = empty ? SENTINEL : 48'(mem[rd_ptr]);

   always_comb begin
      status             = '0;
      status[CNT_W-1:0]  = count;
      status[15]         = full;
      status[14]         = empty;
      status[13]         = overflow;
   end

   always_comb begin
      rd_mux = '0;
      case (address)
         3'd0:    rd_mux = stage[31:16];
         3'd1:    rd_mux = stage[15:0];
         3'd3:    rd_mux = status;
         default: rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk50 or posedge reset) begin
      if (reset) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         stage    <= '0;
         overflow <= 1'b0;
         readdata <= '0;
      end else begin
         if (wr_en && address == 3'd0) stage[31:16] <= writedata;
         if (wr_en && address == 3'd1) stage[15:0]  <= writedata;

         if (pop)     rd_ptr <= ptr_inc(rd_ptr);
         if (push_ok) wr_ptr <= ptr_inc(wr_ptr);

         case ({push_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase

         // Set has priority over clear.
         if (push_rej)     overflow <= 1'b1;
         else if (ovf_clr) overflow <= 1'b0;

         if (rd_en) readdata <= rd_mux;
      end
   end

   // Storage carries no reset; count==0 masks stale contents.
   always_ff @(posedge clk50) begin
      if (push_ok) mem[wr_ptr] <= push_instr;
   end

endmodule

// File: doc/render_queue.md
# render_queue

Avalon-MM slave that collects 48-bit sprite draw instructions from software and buffers them in a FIFO for `vga_display`. `vga_display` reads the head entry on `render_queue_dout` and removes it with `render_queue_pop_front`. Software writes each instruction as three 16-bit words; the third write commits it. When the queue is empty, the head output is the render sentinel (magic 8'hFF), so the display stage idles until more instructions arrive.

## Interface
- `DEPTH`, 25: queue capacity in instructions.
- `CNT_W`, `$clog2(DEPTH+1)`: occupancy counter width; must be ≤ 13.
- `clk50`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `chipselect`  in  1  Avalon slave select.
- `write`  in  1  Avalon write strobe; acts only with `chipselect`.
- `read`  in  1  Avalon read strobe; acts only with `chipselect`.
- `address`  in  3  register select.
- `writedata`  in  16  write data.
- `readdata`  out  16  read data; registered, read latency 1.
- `render_queue_dout`  out  48  head instruction `{magic[7:0], x[15:0], y[15:0], flags[7:0]}`, or the sentinel when empty.
- `render_queue_pop_front`  in  1  consumer pop request.

## Operation
- **Register map (write):**
  - addr 0: stage[47:32].
  - addr 1: stage[31:16].
  - addr 2: push `{stage[47:16], writedata}` into the queue. The staging register keeps its contents, so software can resend only the low word.
  - addr 4: any write clears the sticky `overflow` flag.
  - addr 3, 5–7: writes ignored.
- **Register map (read):**
  - addr 3: status = `{full, empty, overflow, 0…, count[CNT_W-1:0]}`, with `full` in bit 15, `empty` in bit 14, `overflow` in bit 13, and `count` in the low bits.
  - addr 0/1: stage halves.
  - other addresses: 0.
- **Storage:** circular buffer of DEPTH×48 registers with `rd_ptr`, `wr_ptr`, and `count`. Pointers wrap from DEPTH-1 to 0 (DEPTH need not be a power of 2).
- **Pop:** `pop = render_queue_pop_front & (count != 0)`. A pop advances `rd_ptr` and decrements `count`. A pop on an empty queue is ignored and has no side effects.
- **Push:** `push_req` = `chipselect & write & address==2`.
  - A push is accepted if `count < DEPTH`, or if `pop` is asserted in the same cycle.
  - An accepted push writes `mem[wr_ptr]` and advances `wr_ptr`.
  - A rejected push drops the instruction and sets `overflow`. `overflow` stays set until a write to addr 4 or `reset`.
- **Push and pop in the same cycle:** `count` is unchanged and both pointers advance. When `count==1`, the popped entry is the old head and the new entry becomes the head.
- **Head output:** `render_queue_dout = (count==0) ? 48'hFF00_0000_0000 : mem[rd_ptr]`. This is combinational from registers, so the consumer sees the head the same cycle and can sample it on any edge.
- **Status flags:** `full = (count==DEPTH)`, `empty = (count==0)`.
- **Overflow set and clear in the same cycle:** set wins.

## Timing
- **Reset values:** `count`, `rd_ptr`, `wr_ptr`, `stage`, `overflow`, and `readdata` are all 0; `render_queue_dout` = 48'hFF00_0000_0000.
- **Reset mid-operation:** contents are discarded immediately (asynchronous). `mem` contents need not be reset.
- **Push latency:** a push on edge N makes the entry visible on `render_queue_dout` after edge N if the queue was empty. `count` updates at edge N.
- **Pop latency:** a pop sampled at edge N moves `render_queue_dout` to the next entry, or to the sentinel, immediately after edge N.
- **Read latency:** `readdata` is valid the cycle after `read`. The status value reflects state before the edge on which `read` is sampled. `readdata` holds its value when no read is in progress.
- **Throughput:** one push and one pop per cycle, sustained.
- **Wait states:** none; no `waitrequest`.
- **Stage writes:** a write to addr 0 or 1 in the same cycle as a push to addr 2 is impossible (single address bus). The push uses the stage value before the edge.

## Test plan
- **Reset:** assert `reset` mid-cycle with 3 entries queued → `count`=0 immediately, `dout`=48'hFF00_0000_0000, status read = 16'h4000.
- **Single push/pop:** write addr0=16'h0112, addr1=16'h3400, addr2=16'h5601 → next cycle `dout`=48'h0112_3400_5601 and status = 16'h0001. Then pulse pop once → `dout` = sentinel, status = 16'h4000.
- **Fill and overflow:** push 25 distinct entries → status = 16'h8019. A 26th push is dropped and status = 16'hA019. Write addr4 → 16'h8019. Pop all 25 → order matches push order, including across the pointer wrap.
- **Simultaneous at full:** with 25 queued, push and pop in the same cycle → push accepted, `count` stays 25, `overflow` stays 0. The new entry is output after 24 more pops.
- **Pop on empty:** hold `render_queue_pop_front` high for 10 cycles on an empty queue → `count` stays 0 and the pointers are unchanged. A subsequent push appears on `dout` and is popped the next cycle.
- **Stage reuse:** push once, then write only addr2 three times with 0, 1, 2 → the three new entries share the upper 32 bits and have low words 0, 1, 2.
